// File: rtl/tick_downcounter_pkg.sv
// Shared constants for the tick-gated down-counter
// and the display blocks that reuse its time base.
package tick_downcounter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // 100 MHz board clock divided down to a 1 Hz strobe
  localparam int TICK_DIV_BOARD = 100_000_000;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle strobe
// every TICK_DIV clocks; restart re-phases it.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_tick;
  logic          w_last;

  assign w_last = (r_div_cnt == LAST);
  assign tick   = r_tick;

  // divider phase and registered strobe
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= w_last;
      r_div_cnt <= w_last ? '0 : r_div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/tick_downcounter.sv
// Down-counter stepped by the shared slow tick,
// with load, wrap/saturate at zero and tc pulse.
module tick_downcounter
  import tick_downcounter_pkg::*;
#(
  parameter int   WIDTH    = 4,
  parameter int   TICK_DIV = TICK_DIV_BOARD,
  parameter logic MODE     = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             zero
);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             w_tick;
  logic             w_step;
  logic             w_hit_zero;
  logic [WIDTH-1:0] w_q_nxt;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .tick    (w_tick)
  );

  assign w_step     = en && w_tick;
  assign w_hit_zero = (r_q == WIDTH'(1));

  // value taken on a step: decrement, or wrap/hold at 0
  always_comb begin
    w_q_nxt = r_q - WIDTH'(1);
    if (r_q == '0) begin
      w_q_nxt = (MODE == MODE_WRAP) ? '1 : r_q;
    end
  end

  // count register and terminal-count pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else if (load) begin
      r_q  <= load_val;
      r_tc <= 1'b0;
    end else if (w_step) begin
      r_q  <= w_q_nxt;
      r_tc <= w_hit_zero;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign tick = w_tick;
  assign zero = (r_q == '0);

endmodule

// File: tb/tb_tick_downcounter.sv
// Directed bench: WRAP and SAT copies at TICK_DIV=4,
// plus a WIDTH=1 TICK_DIV=2 toggle check.
module tb_tick_downcounter;
  import tick_downcounter_pkg::*;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic [3:0] lv;
    logic [3:0] qw;
    logic [3:0] qs;
    logic       tk;
    logic       tc;
  } vec_t;

  vec_t vq[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q_w, q_s;
  logic       tk_w, tk_s, tc_w, tc_s, z_w, z_s;

  logic       rst2 = 1'b1;
  logic       load2 = 1'b0;
  logic       en2 = 1'b0;
  logic [0:0] lv2 = '0;
  logic [0:0] q2;
  logic       tk2, tc2, z2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tick_downcounter #(
    .WIDTH(4), .TICK_DIV(4), .MODE(MODE_WRAP)
  ) u_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_val(load_val), .q(q_w), .tick(tk_w),
    .tc(tc_w), .zero(z_w)
  );

  tick_downcounter #(
    .WIDTH(4), .TICK_DIV(4), .MODE(MODE_SAT)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_val(load_val), .q(q_s), .tick(tk_s),
    .tc(tc_s), .zero(z_s)
  );

  tick_downcounter #(
    .WIDTH(1), .TICK_DIV(2), .MODE(MODE_WRAP)
  ) u_div2 (
    .clk(clk), .rst(rst2), .en(en2), .load(load2),
    .load_val(lv2), .q(q2), .tick(tk2),
    .tc(tc2), .zero(z2)
  );

  task automatic chk(input string nm, input int idx,
                     input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, want %0d",
               nm, idx, act, exp);
    end
  endtask

  task automatic add(input int n,
                     input logic r, input logic l,
                     input logic e, input logic [3:0] v,
                     input logic [3:0] qw, input logic [3:0] qs,
                     input logic tk, input logic tc);
    repeat (n) vq.push_back('{r, l, e, v, qw, qs, tk, tc});
  endtask

  initial begin
    // reset, then free count in WRAP (SAT stays at 0)
    add(1, 1,0,0,0,  0,0, 0,0);
    add(3, 0,0,1,0,  0,0, 0,0);
    add(1, 0,0,1,0,  0,0, 1,0);
    add(3, 0,0,1,0, 15,0, 0,0);
    add(1, 0,0,1,0, 15,0, 1,0);
    add(3, 0,0,1,0, 14,0, 0,0);
    add(1, 0,0,1,0, 14,0, 1,0);
    // load 2 on a tick cycle, count down to 0
    add(1, 0,1,1,2,  2,2, 0,0);
    add(3, 0,0,1,0,  2,2, 0,0);
    add(1, 0,0,1,0,  2,2, 1,0);
    add(3, 0,0,1,0,  1,1, 0,0);
    add(1, 0,0,1,0,  1,1, 1,0);
    add(1, 0,0,1,0,  0,0, 0,1);
    add(2, 0,0,1,0,  0,0, 0,0);
    add(1, 0,0,1,0,  0,0, 1,0);
    add(1, 0,0,1,0, 15,0, 0,0);
    // q=5, load 9 while tick is high
    add(1, 0,1,1,5,  5,5, 0,0);
    add(3, 0,0,1,0,  5,5, 0,0);
    add(1, 0,0,1,0,  5,5, 1,0);
    add(1, 0,1,1,9,  9,9, 0,0);
    add(3, 0,0,1,0,  9,9, 0,0);
    add(1, 0,0,1,0,  9,9, 1,0);
    add(1, 0,0,1,0,  8,8, 0,0);
    // q=7 with en low across two ticks
    add(1, 0,1,0,7,  7,7, 0,0);
    add(3, 0,0,0,0,  7,7, 0,0);
    add(1, 0,0,0,0,  7,7, 1,0);
    add(3, 0,0,0,0,  7,7, 0,0);
    add(1, 0,0,0,0,  7,7, 1,0);
    add(1, 0,0,0,0,  7,7, 0,0);
    add(2, 0,0,1,0,  7,7, 0,0);
    add(1, 0,0,1,0,  7,7, 1,0);
    add(1, 0,0,1,0,  6,6, 0,0);
    // rst at div_cnt=2, q=3; then rst with load
    add(1, 0,1,1,3,  3,3, 0,0);
    add(2, 0,0,1,0,  3,3, 0,0);
    add(1, 1,0,1,0,  0,0, 0,0);
    add(3, 0,0,1,0,  0,0, 0,0);
    add(1, 0,0,1,0,  0,0, 1,0);
    add(1, 1,1,1,9,  0,0, 0,0);
    add(1, 0,0,0,0,  0,0, 0,0);

    foreach (vq[i]) begin
      rst      = vq[i].rst;
      load     = vq[i].load;
      en       = vq[i].en;
      load_val = vq[i].lv;
      @(posedge clk);
      #1;
      chk("q_wrap", i, 32'(q_w), 32'(vq[i].qw));
      chk("q_sat", i, 32'(q_s), 32'(vq[i].qs));
      chk("tick", i, 32'(tk_w), 32'(vq[i].tk));
      chk("tick_sat", i, 32'(tk_s), 32'(vq[i].tk));
      chk("tc_wrap", i, 32'(tc_w), 32'(vq[i].tc));
      chk("tc_sat", i, 32'(tc_s), 32'(vq[i].tc));
      chk("zero_wrap", i, 32'(z_w),
          (vq[i].qw == 4'd0) ? 1 : 0);
      chk("zero_sat", i, 32'(z_s),
          (vq[i].qs == 4'd0) ? 1 : 0);
    end

    // WIDTH=1, TICK_DIV=2: q toggles, tc on 1->0
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    chk("d2_rst_q", 0, 32'(q2), 0);
    chk("d2_rst_tick", 0, 32'(tk2), 0);
    chk("d2_rst_tc", 0, 32'(tc2), 0);
    chk("d2_rst_zero", 0, 32'(z2), 1);
    rst2 = 1'b0;
    en2  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int eq;
      @(posedge clk);
      #1;
      eq = (k < 3) ? 0 : (((k - 1) / 2) % 2);
      chk("d2_q", k, 32'(q2), eq);
      chk("d2_tick", k, 32'(tk2), (k % 2 == 0) ? 1 : 0);
      chk("d2_tc", k, 32'(tc2),
          (k >= 5 && k % 4 == 1) ? 1 : 0);
      chk("d2_zero", k, 32'(z2), (eq == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
